// File: rtl/clkgate_pkg.sv
// Shared definitions for the multi-channel clock gate: channel state encoding,
// counter sizing and parameter range validation.
package clkgate_pkg;

  typedef enum logic [1:0] {
    CG_OFF  = 2'b00,
    CG_WAKE = 2'b01,
    CG_ON   = 2'b10
  } cg_state_e;

  // Counter must hold the larger of the idle and wake thresholds; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned idle_cyc, input int unsigned wake_cyc);
    int unsigned mx;
    mx = (idle_cyc > wake_cyc) ? idle_cyc : wake_cyc;
    return (mx < 32'd1) ? 32'd1 : $clog2(mx + 32'd1);
  endfunction

  function automatic bit params_ok(input int unsigned nch, input int unsigned idle_cyc,
                                   input int unsigned wake_cyc, input int unsigned auto_gate);
    return (nch >= 32'd1) && (nch <= 32'd32) &&
           (idle_cyc >= 32'd1) && (idle_cyc <= 32'd255) &&
           (wake_cyc <= 32'd255) && (auto_gate <= 32'd1);
  endfunction

endpackage

// File: rtl/clkgate_cell.sv
// One-bit clock gate: enable latch transparent during the CK low phase, ANDed with CK.
// Define CLKGATE_LIB_CELL to map onto the CLKGATE library cell at synthesis.
module clkgate_cell (
  input  logic CK,
  input  logic D,
  input  logic RST,
  output logic GCK,
  output logic Q
);

`ifdef CLKGATE_LIB_CELL
  CLKGATE u_lib (.CK(CK), .E(D), .RST(RST), .GCK(GCK), .Q(Q));
`else
  logic q_r;

  // Enable latch: captures D while CK is low, cleared asynchronously by RST
  always_latch begin
    if (RST) begin
      q_r <= 1'b0;
    end else if (!CK) begin
      q_r <= D;
    end
  end

  assign GCK = CK & q_r;
  assign Q   = q_r;
`endif

endmodule

// File: rtl/clkgate_mc.sv
// NCH independently gated clocks from root CK, each with an OFF/WAKE/ON control FSM,
// idle-driven auto-gating, wake latency with ready flag and a global scan override.
module clkgate_mc #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned IDLE_CYC = 8,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned AUTO     = 1
) (
  input  logic           CK,
  input  logic           RST,
  input  logic           TE,
  input  logic [NCH-1:0] EN,
  input  logic [NCH-1:0] ACT,
  output logic [NCH-1:0] GCK,
  output logic [NCH-1:0] RDY,
  output logic [NCH-1:0] GATED
);
  import clkgate_pkg::*;

  localparam int unsigned   CW        = cnt_width(IDLE_CYC, WAKE_CYC);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 32'd1);
  localparam logic [CW-1:0] WAKE_LAST = CW'((WAKE_CYC == 32'd0) ? 32'd0 : (WAKE_CYC - 32'd1));
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic          AUTO_ON   = (AUTO != 32'd0);

  if (!params_ok(NCH, IDLE_CYC, WAKE_CYC, AUTO)) begin : g_param_err
    $fatal(1, "clkgate_mc: parameter out of range");
  end

  // Scan mode keeps the latches out of reset so test clocks free-run even under RST.
  logic cell_rst_s;
  assign cell_rst_s = RST & ~TE;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cg_state_e     state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          ge_r, rdy_r, wake_s, idle_s, q_s;

    assign wake_s = EN[i] & (ACT[i] | ~AUTO_ON);
    assign idle_s = AUTO_ON & ~ACT[i];

    // Next-state and counter logic; EN low always wins over activity and counters
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
        CG_OFF: begin
          cnt_nxt_s = '0;
          if (wake_s) begin
            state_nxt_s = (WAKE_CYC == 32'd0) ? CG_ON : CG_WAKE;
          end else begin
            state_nxt_s = CG_OFF;
          end
        end
        CG_WAKE: begin
          if (!EN[i]) begin
            state_nxt_s = CG_OFF;
            cnt_nxt_s   = '0;
          end else if (cnt_r == WAKE_LAST) begin
            state_nxt_s = CG_ON;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s   = cnt_r + 1'b1;
          end
        end
        CG_ON: begin
          if (!EN[i]) begin
            state_nxt_s = CG_OFF;
            cnt_nxt_s   = '0;
          end else if (!idle_s) begin
            cnt_nxt_s   = '0;
          end else if (cnt_r == IDLE_LAST) begin
            state_nxt_s = CG_OFF;
            cnt_nxt_s   = '0;
          end else if (cnt_r != CNT_MAX) begin
            cnt_nxt_s   = cnt_r + 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r;
          end
        end
        default: begin
          state_nxt_s = CG_OFF;
          cnt_nxt_s   = '0;
        end
      endcase
    end

    // State, counter and registered gate-enable / ready flags
    always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
        state_r <= CG_OFF;
        cnt_r   <= '0;
        ge_r    <= 1'b0;
        rdy_r   <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
        ge_r    <= (state_nxt_s != CG_OFF);
        rdy_r   <= (state_nxt_s == CG_ON);
      end
    end

    clkgate_cell u_cell (
      .CK  (CK),
      .D   (ge_r | TE),
      .RST (cell_rst_s),
      .GCK (GCK[i]),
      .Q   (q_s)
    );

    assign RDY[i]   = rdy_r;
    assign GATED[i] = ~q_s;
  end

endmodule

// File: tb/tb_clkgate_mc.sv
// Self-checking bench for clkgate_mc: directed timeline scenarios plus randomized
// traffic compared against a behavioural per-channel model.
module tb_clkgate_mc;
  localparam int NCH = 4, IDLE_CYC = 8, WAKE_CYC = 2, AUTO = 1, HALF = 5;

  logic           CK, RST, TE;
  logic [NCH-1:0] EN, ACT, GCK, RDY, GATED;

  int checks = 0, failures = 0;

  clkgate_mc #(.NCH(NCH), .IDLE_CYC(IDLE_CYC), .WAKE_CYC(WAKE_CYC), .AUTO(AUTO)) dut (
    .CK(CK), .RST(RST), .TE(TE), .EN(EN), .ACT(ACT), .GCK(GCK), .RDY(RDY), .GATED(GATED)
  );

  initial begin
    CK = 1'b0;
    forever #HALF CK = ~CK;
  end

  // Behavioural model: running / waking flags with elapsed-cycle tallies.
  bit m_on[NCH];
  bit m_waking[NCH];
  int m_elapsed[NCH];
  int m_idle[NCH];
  logic [NCH-1:0] exp_gck_hi, obs_gck_hi, obs_rdy_hi;
  logic cur_te;

  function automatic logic [NCH-1:0] model_ge();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_on[i] | m_waking[i];
    return v;
  endfunction

  function automatic logic [NCH-1:0] model_rdy();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_on[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_on[i] = 1'b0; m_waking[i] = 1'b0; m_elapsed[i] = 0; m_idle[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [NCH-1:0] en, input logic [NCH-1:0] act);
    for (int i = 0; i < NCH; i++) begin
      if (m_on[i]) begin
        if (!en[i]) m_on[i] = 1'b0;
        else if (AUTO != 0 && act[i]) m_idle[i] = 0;
        else if (AUTO != 0) begin
          m_idle[i]++;
          if (m_idle[i] >= IDLE_CYC) m_on[i] = 1'b0;
        end
      end else if (m_waking[i]) begin
        if (!en[i]) m_waking[i] = 1'b0;
        else begin
          m_elapsed[i]++;
          if (m_elapsed[i] >= WAKE_CYC) begin
            m_waking[i] = 1'b0; m_on[i] = 1'b1; m_idle[i] = 0;
          end
        end
      end else if (en[i] && (act[i] || AUTO == 0)) begin
        if (WAKE_CYC == 0) begin m_on[i] = 1'b1; m_idle[i] = 0; end
        else begin m_waking[i] = 1'b1; m_elapsed[i] = 0; end
      end
    end
  endtask

  // Called in a low phase: drive inputs, cross one rising edge, sample the high phase,
  // and return one time unit into the following low phase.
  task automatic step(input logic [NCH-1:0] en, input logic [NCH-1:0] act, input logic te);
    EN = en; ACT = act; TE = te; cur_te = te;
    @(posedge CK);
    exp_gck_hi = model_ge() | {NCH{te}};
    model_edge(en, act);
    #1;
    obs_gck_hi = GCK;
    obs_rdy_hi = RDY;
    @(negedge CK);
    #1;
  endtask

  // Pulse-width monitor on channel 3
  time t_rise;
  int  pulses, runts;
  bit  mon_en;
  always @(posedge GCK[3]) t_rise <= $time;
  always @(negedge GCK[3]) begin
    if (mon_en) begin
      pulses <= pulses + 1;
      if ($time - t_rise != HALF) runts <= runts + 1;
    end
  end

  task automatic test_reset();
    RST = 1'b1; TE = 1'b0; EN = 4'hF; ACT = 4'h0; cur_te = 1'b0;
    model_reset();
    repeat (2) @(posedge CK);
    #1;
    checks++; if (GCK !== 4'h0) begin failures++; $display("FAIL reset_gck got=%h exp=%h", GCK, 4'h0); end
    checks++; if (RDY !== 4'h0) begin failures++; $display("FAIL reset_rdy got=%h exp=%h", RDY, 4'h0); end
    checks++; if (GATED !== 4'hF) begin failures++; $display("FAIL reset_gated got=%h exp=%h", GATED, 4'hF); end
    @(negedge CK); #1;
    RST = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step(4'hF, 4'h0, 1'b0);
      checks++; if (obs_gck_hi !== 4'h0) begin failures++; $display("FAIL idle_gck cyc=%0d got=%h exp=%h", j, obs_gck_hi, 4'h0); end
      checks++; if (obs_rdy_hi !== 4'h0) begin failures++; $display("FAIL idle_rdy cyc=%0d got=%h exp=%h", j, obs_rdy_hi, 4'h0); end
      checks++; if (GATED !== 4'hF) begin failures++; $display("FAIL idle_gated cyc=%0d got=%h exp=%h", j, GATED, 4'hF); end
    end
  endtask

  task automatic test_wake_idle();
    for (int j = 0; j < 14; j++) begin
      logic eg, er;
      step(4'hF, (j == 0) ? 4'b0001 : 4'b0000, 1'b0);
      eg = (j >= 1 && j <= 10);
      er = (j >= 2 && j <= 9);
      checks++; if (obs_gck_hi[0] !== eg) begin failures++; $display("FAIL wake_gck0 cyc=%0d got=%b exp=%b", j, obs_gck_hi[0], eg); end
      checks++; if (obs_rdy_hi[0] !== er) begin failures++; $display("FAIL wake_rdy0 cyc=%0d got=%b exp=%b", j, obs_rdy_hi[0], er); end
    end
  endtask

  task automatic test_act_periodic();
    for (int j = 0; j < 42; j++) begin
      step(4'hF, (j % 7 == 0) ? 4'b0010 : 4'b0000, 1'b0);
      checks++; if (obs_gck_hi[1] !== (j >= 1)) begin failures++; $display("FAIL periodic_gck1 cyc=%0d got=%b exp=%b", j, obs_gck_hi[1], (j >= 1)); end
      checks++; if (obs_rdy_hi[1] !== (j >= 2)) begin failures++; $display("FAIL periodic_rdy1 cyc=%0d got=%b exp=%b", j, obs_rdy_hi[1], (j >= 2)); end
    end
  endtask

  task automatic test_en_drop();
    repeat (3) step(4'hF, 4'b0100, 1'b0);
    checks++; if (obs_rdy_hi[2] !== 1'b1) begin failures++; $display("FAIL endrop_rdy_on got=%b exp=1", obs_rdy_hi[2]); end
    step(4'b1011, 4'b0100, 1'b0);
    checks++; if (obs_rdy_hi[2] !== 1'b0) begin failures++; $display("FAIL endrop_rdy_off got=%b exp=0", obs_rdy_hi[2]); end
    checks++; if (obs_gck_hi[2] !== 1'b1) begin failures++; $display("FAIL endrop_last_pulse got=%b exp=1", obs_gck_hi[2]); end
    step(4'b1011, 4'b0100, 1'b0);
    checks++; if (obs_gck_hi[2] !== 1'b0) begin failures++; $display("FAIL endrop_no_pulse got=%b exp=0", obs_gck_hi[2]); end
    step(4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_te();
    for (int j = 0; j < 3; j++) begin
      step(4'h0, 4'h0, 1'b1);
      checks++; if (obs_gck_hi !== 4'hF) begin failures++; $display("FAIL te_gck cyc=%0d got=%h exp=%h", j, obs_gck_hi, 4'hF); end
      checks++; if (obs_rdy_hi !== 4'h0) begin failures++; $display("FAIL te_rdy cyc=%0d got=%h exp=%h", j, obs_rdy_hi, 4'h0); end
      checks++; if (GATED !== 4'h0) begin failures++; $display("FAIL te_gated cyc=%0d got=%h exp=%h", j, GATED, 4'h0); end
      checks++; if (GCK !== 4'h0) begin failures++; $display("FAIL te_gck_low cyc=%0d got=%h exp=%h", j, GCK, 4'h0); end
    end
    step(4'h0, 4'h0, 1'b0);
    checks++; if (obs_gck_hi !== 4'h0) begin failures++; $display("FAIL te_off_gck got=%h exp=%h", obs_gck_hi, 4'h0); end
    checks++; if (GATED !== 4'hF) begin failures++; $display("FAIL te_off_gated got=%h exp=%h", GATED, 4'hF); end
  endtask

  task automatic test_glitch();
    int exp_pulses;
    exp_pulses = 0;
    pulses = 0; runts = 0; mon_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      logic b;
      b = (j % 2 == 0);
      step({b, 3'b000}, 4'b1000, 1'b0);
      exp_pulses += int'(exp_gck_hi[3]);
      checks++; if (obs_gck_hi[3] !== exp_gck_hi[3]) begin failures++; $display("FAIL glitch_gck3 cyc=%0d got=%b exp=%b", j, obs_gck_hi[3], exp_gck_hi[3]); end
    end
    mon_en = 1'b0;
    checks++; if (runts !== 0) begin failures++; $display("FAIL glitch_runts got=%0d exp=0", runts); end
    checks++; if (pulses !== exp_pulses) begin failures++; $display("FAIL glitch_pulses got=%0d exp=%0d", pulses, exp_pulses); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 300; j++) begin
      logic [NCH-1:0] en, act, eg;
      logic te;
      for (int i = 0; i < NCH; i++) begin
        en[i]  = ($urandom_range(7, 0) != 0);
        act[i] = ($urandom_range(5, 0) == 0);
      end
      te = ($urandom_range(19, 0) == 0);
      step(en, act, te);
      eg = ~(model_ge() | {NCH{te}});
      checks++; if (obs_gck_hi !== exp_gck_hi) begin failures++; $display("FAIL rand_gck cyc=%0d got=%h exp=%h", j, obs_gck_hi, exp_gck_hi); end
      checks++; if (obs_rdy_hi !== model_rdy()) begin failures++; $display("FAIL rand_rdy cyc=%0d got=%h exp=%h", j, obs_rdy_hi, model_rdy()); end
      checks++; if (GATED !== eg) begin failures++; $display("FAIL rand_gated cyc=%0d got=%h exp=%h", j, GATED, eg); end
    end
    step(4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    repeat (3) step(4'b0001, 4'b0001, 1'b0);
    checks++; if (obs_rdy_hi[0] !== 1'b1) begin failures++; $display("FAIL rstmid_pre_rdy got=%b exp=1", obs_rdy_hi[0]); end
    @(posedge CK);
    #2;
    RST = 1'b1;
    #1;
    checks++; if (GCK !== 4'h0) begin failures++; $display("FAIL rstmid_gck got=%h exp=%h", GCK, 4'h0); end
    checks++; if (RDY !== 4'h0) begin failures++; $display("FAIL rstmid_rdy got=%h exp=%h", RDY, 4'h0); end
    checks++; if (GATED !== 4'hF) begin failures++; $display("FAIL rstmid_gated got=%h exp=%h", GATED, 4'hF); end
    @(negedge CK); #1;
    RST = 1'b0;
    model_reset();
    step(4'h0, 4'h0, 1'b0);
    checks++; if (obs_gck_hi !== 4'h0) begin failures++; $display("FAIL rstmid_post_gck got=%h exp=%h", obs_gck_hi, 4'h0); end
  endtask

  initial begin
    mon_en = 1'b0; pulses = 0; runts = 0;
    test_reset();
    test_wake_idle();
    test_act_periodic();
    test_en_drop();
    test_te();
    test_glitch();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
